// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: WB and LL write requests in, register-file write port
// and reservation release out. The arbiter uses the slave modport and the requester side uses the master modport.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic                   stall_WB;
  logic                   ll_valid;
  logic                   ll_ready;
  logic [4:0]             ll_rd;
  logic [XLEN-1:0]        ll_data;
  logic                   rf_we;
  logic [4:0]             rf_rd;
  logic [XLEN-1:0]        rf_wdata;
  logic                   rel_valid;
  logic [4:0]             rel_rd;
  logic [$clog2(DEPTH):0] ll_count;

  modport master (
    output wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
    input  stall_WB, ll_ready, rf_we, rf_rd, rf_wdata, rel_valid, rel_rd, ll_count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
    output stall_WB, ll_ready, rf_we, rf_rd, rf_wdata, rel_valid, rel_rd, ll_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB has priority, LL results queue in a FIFO and drain into
// idle slots, with a starvation-forced LL slot. Define WB_ARB_WAW_KILL_EN for WAW kill bits.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [SW-1:0]   starve_reg, starve_next;
  logic            fifo_empty, fifo_full;
  logic            push, pop, grant_wb;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            head_kill;
  logic            rf_we_reg, rel_valid_reg;
  logic [4:0]      rf_rd_reg;
  logic [XLEN-1:0] rf_wdata_reg;

  // Full is taken from the registered count only, so a same-cycle pop never opens a slot early.
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign push       = bus.ll_valid & ~fifo_full;
  assign head_rd    = fifo_rd[rd_ptr_reg];
  assign head_data  = fifo_data[rd_ptr_reg];

  always_comb begin
    state_next  = ST_NORMAL;
    grant_wb    = 1'b0;
    pop         = 1'b0;
    starve_next = starve_reg;
    case (state_reg)
      ST_FORCE: begin
        pop         = ~fifo_empty;
        starve_next = '0;
        state_next  = ST_NORMAL;
      end
      default: begin
        if (bus.wb_valid) begin
          grant_wb = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
        if (pop) begin
          starve_next = '0;
        end else if (grant_wb && !fifo_empty) begin
          starve_next = starve_reg + 1'b1;
        end
        if (starve_next >= STARVE_LIM) begin
          state_next = ST_FORCE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_NORMAL;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr_reg]   <= bus.ll_rd;
      fifo_data[wr_ptr_reg] <= bus.ll_data;
    end
  end

`ifdef WB_ARB_WAW_KILL_EN
  logic [DEPTH-1:0] kill_reg;

  // A newly pushed entry is younger than the concurrent WB write, so push clears rather than kills.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          kill_reg[gi] <= 1'b0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          kill_reg[gi] <= 1'b0;
        end else if (grant_wb && (bus.wb_rd != 5'd0) && (fifo_rd[gi] == bus.wb_rd)) begin
          kill_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign head_kill = kill_reg[rd_ptr_reg];
`else
  assign head_kill = 1'b0;
`endif

  // x0 writes are consumed but never written or released; killed entries release without writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we_reg     <= 1'b0;
      rel_valid_reg <= 1'b0;
      rf_rd_reg     <= '0;
      rf_wdata_reg  <= '0;
    end else if (grant_wb) begin
      rf_we_reg     <= (bus.wb_rd != 5'd0);
      rel_valid_reg <= (bus.wb_rd != 5'd0);
      rf_rd_reg     <= bus.wb_rd;
      rf_wdata_reg  <= bus.wb_data;
    end else if (pop) begin
      rf_we_reg     <= (head_rd != 5'd0) & ~head_kill;
      rel_valid_reg <= (head_rd != 5'd0);
      rf_rd_reg     <= head_rd;
      rf_wdata_reg  <= head_data;
    end else begin
      rf_we_reg     <= 1'b0;
      rel_valid_reg <= 1'b0;
      rf_rd_reg     <= '0;
      rf_wdata_reg  <= '0;
    end
  end

  assign bus.stall_WB  = (state_reg == ST_FORCE) & bus.wb_valid;
  assign bus.ll_ready  = ~fifo_full;
  assign bus.ll_count  = count_reg;
  assign bus.rf_we     = rf_we_reg;
  assign bus.rf_rd     = rf_rd_reg;
  assign bus.rf_wdata  = rf_wdata_reg;
  assign bus.rel_valid = rel_valid_reg;
  assign bus.rel_rd    = rf_rd_reg;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a transaction-level model predicts each cycle's
// write-port result, which is queued at drive time and compared when the DUT registers it.
module tb_wb_port_arbiter;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { bit v; logic [4:0] rd; logic [31:0] data; } req_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; bit kill; } ent_t;
  typedef struct { bit we; bit rel; logic [4:0] rd; logic [31:0] data; } wr_t;

  req_t       wb_pend[$];
  req_t       ll_pend[$];
  ent_t       m_fifo[$];
  wr_t        exp_q[$];
  logic [4:0] wr_log[$];
  int         m_starve = 0;
  bit         m_force = 1'b0;
  int         stall_seen = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void add_wb(input bit v, input logic [4:0] rd, input logic [31:0] d);
    wb_pend.push_back('{v: v, rd: rd, data: d});
  endfunction

  function automatic void add_ll(input bit v, input logic [4:0] rd, input logic [31:0] d);
    ll_pend.push_back('{v: v, rd: rd, data: d});
  endfunction

  function automatic int find_rd(input logic [4:0] rd);
    foreach (wr_log[i]) if (wr_log[i] == rd) return i;
    return -1;
  endfunction

  task automatic one_cycle(input req_t w, input req_t l, output bit w_done, output bit l_done);
    wr_t  e;
    ent_t h;
    bit   exp_ready, exp_stall, nonempty, wb_granted, popped;
    @(negedge clk);
    bus.wb_valid = w.v;
    bus.wb_rd    = w.rd;
    bus.wb_data  = w.data;
    bus.ll_valid = l.v;
    bus.ll_rd    = l.rd;
    bus.ll_data  = l.data;
    #1;
    exp_ready = (m_fifo.size() < DEPTH);
    exp_stall = m_force && w.v;
    nonempty  = (m_fifo.size() != 0);
    check_eq("ll_ready", 64'(bus.ll_ready), 64'(exp_ready));
    check_eq("ll_count", 64'(bus.ll_count), 64'(m_fifo.size()));
    check_eq("stall_WB", 64'(bus.stall_WB), 64'(exp_stall));
    if (bus.stall_WB) stall_seen++;

    e = '{we: 1'b0, rel: 1'b0, rd: 5'd0, data: 32'd0};
    wb_granted = 1'b0;
    popped     = 1'b0;
    if (!m_force && w.v) begin
      wb_granted = 1'b1;
      e = '{we: (w.rd != 0), rel: (w.rd != 0), rd: w.rd, data: w.data};
`ifdef WB_ARB_WAW_KILL_EN
      if (w.rd != 0) foreach (m_fifo[i]) if (m_fifo[i].rd == w.rd) m_fifo[i].kill = 1'b1;
`endif
    end else if (nonempty) begin
      h = m_fifo.pop_front();
      popped = 1'b1;
      e = '{we: (h.rd != 0) && !h.kill, rel: (h.rd != 0), rd: h.rd, data: h.data};
    end
    if (l.v && exp_ready) m_fifo.push_back('{rd: l.rd, data: l.data, kill: 1'b0});
    w_done = !w.v || wb_granted;
    l_done = !l.v || exp_ready;

    if (m_force || popped) m_starve = 0;
    else if (wb_granted && nonempty) m_starve++;
    if (m_force) m_force = 1'b0;
    else m_force = (m_starve >= STARVE_MAX);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("rf_we", 64'(bus.rf_we), 64'(e.we));
    check_eq("rel_valid", 64'(bus.rel_valid), 64'(e.rel));
    if (e.we) begin
      check_eq("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
      check_eq("rf_wdata", 64'(bus.rf_wdata), 64'(e.data));
    end
    if (e.rel) check_eq("rel_rd", 64'(bus.rel_rd), 64'(e.rd));
    if (bus.rf_we) wr_log.push_back(bus.rf_rd);
  endtask

  task automatic drain(input int max_cycles, input bit to_empty);
    req_t idle, w, l;
    bit   wt, lt;
    int   n;
    idle = '{v: 1'b0, rd: 5'd0, data: 32'd0};
    n = 0;
    while ((wb_pend.size() != 0 || ll_pend.size() != 0 || (to_empty && m_fifo.size() != 0))
           && n < max_cycles) begin
      w = (wb_pend.size() != 0) ? wb_pend[0] : idle;
      l = (ll_pend.size() != 0) ? ll_pend[0] : idle;
      one_cycle(w, l, wt, lt);
      if (wb_pend.size() != 0 && wt) void'(wb_pend.pop_front());
      if (ll_pend.size() != 0 && lt) void'(ll_pend.pop_front());
      n++;
    end
    if (to_empty) check_eq("drain_done", 64'(wb_pend.size() + ll_pend.size() + m_fifo.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t idle;
    bit   wt, lt;
    idle = '{v: 1'b0, rd: 5'd0, data: 32'd0};
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.ll_valid = 1'b0; bus.ll_rd = '0; bus.ll_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check_eq("rst_rel_valid", 64'(bus.rel_valid), 64'd0);
    check_eq("rst_ll_ready", 64'(bus.ll_ready), 64'd1);
    check_eq("rst_ll_count", 64'(bus.ll_count), 64'd0);
    check_eq("rst_stall", 64'(bus.stall_WB), 64'd0);
    reset = 1'b0;

    // LL only: result written two cycles after the handshake
    add_ll(1'b1, 5'd7, 32'hDEADBEEF);
    drain(20, 1'b1);
    check_eq("t1_first_rd", 64'(find_rd(5'd7)), 64'd0);

    // Starvation: four WB writes with a queued LL entry, then one forced LL slot
    wr_log.delete();
    stall_seen = 0;
    add_ll(1'b1, 5'd9, 32'h0000_0099);
    add_wb(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 6; i++) add_wb(1'b1, 5'(i), 32'h100 + 32'(i));
    drain(40, 1'b1);
    check_eq("t2_ll_slot", 64'(find_rd(5'd9)), 64'd4);
    check_eq("t2_stalls", 64'(stall_seen), 64'd1);
    check_eq("t2_writes", 64'(wr_log.size()), 64'd7);

    // Full FIFO under continuous WB traffic
    wr_log.delete();
    for (int i = 0; i < 10; i++) add_wb(1'b1, 5'(16 + i), 32'hA000 + 32'(i));
    for (int i = 0; i < 5; i++) add_ll(1'b1, 5'(10 + i), 32'hB000 + 32'(i));
    drain(80, 1'b1);
    check_eq("t3_writes", 64'(wr_log.size()), 64'd15);

    // x0 destinations are consumed without writing
    wr_log.delete();
    add_wb(1'b1, 5'd0, 32'h1234);
    add_wb(1'b1, 5'd3, 32'h3333);
    add_ll(1'b1, 5'd0, 32'h5678);
    drain(20, 1'b1);
    check_eq("t4_writes", 64'(wr_log.size()), 64'd1);

    // WAW between queued LL rd=5 and a later WB rd=5
    wr_log.delete();
    add_ll(1'b1, 5'd5, 32'h55);
    add_wb(1'b0, 5'd0, 32'd0);
    add_wb(1'b1, 5'd5, 32'h11);
    drain(20, 1'b1);
`ifdef WB_ARB_WAW_KILL_EN
    check_eq("t6_writes", 64'(wr_log.size()), 64'd1);
`else
    check_eq("t6_writes", 64'(wr_log.size()), 64'd2);
`endif

    // Asynchronous reset with three LL entries queued
    for (int i = 0; i < 6; i++) add_wb(1'b1, 5'(20 + i), 32'hC000 + 32'(i));
    for (int i = 0; i < 3; i++) add_ll(1'b1, 5'(26 + i), 32'hD000 + 32'(i));
    drain(4, 1'b0);
    check_eq("t5_queued", 64'(bus.ll_count), 64'd3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_rf_we", 64'(bus.rf_we), 64'd0);
    check_eq("t5_rel_valid", 64'(bus.rel_valid), 64'd0);
    check_eq("t5_ll_count", 64'(bus.ll_count), 64'd0);
    check_eq("t5_ll_ready", 64'(bus.ll_ready), 64'd1);
    m_fifo.delete(); exp_q.delete(); wb_pend.delete(); ll_pend.delete();
    m_starve = 0;
    m_force = 1'b0;
    bus.wb_valid = 1'b0;
    bus.ll_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wr_log.delete();
    repeat (5) one_cycle(idle, idle, wt, lt);
    check_eq("t5_no_write", 64'(wr_log.size()), 64'd0);

    // Random mixed traffic with small rd range to provoke collisions
    for (int i = 0; i < 200; i++)
      add_wb(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
    for (int i = 0; i < 80; i++)
      add_ll(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
    drain(3000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
